// File: rtl/audio_i2s_tx.sv
// I2S transmitter: stereo-pair FIFO, BCLK/LRCLK generation, 64-bclk framing with 16-bit data slots.
// Define AUDIO_I2S_LJ_EN for left-justified framing; the default build is Philips I2S.
module audio_i2s_tx #(
    parameter int unsigned BCLK_DIV = 4,
    parameter int unsigned FIFO_AW  = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [15:0]        sample_l,
    input  logic [15:0]        sample_r,
    input  logic               sample_valid,
    input  logic               clr_flags,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               overflow,
    output logic               underrun,
    output logic               i2s_bclk,
    output logic               i2s_lrclk,
    output logic               i2s_sdata
);

    localparam int unsigned DW    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned DEPTH = 1 << FIFO_AW;
`ifdef AUDIO_I2S_LJ_EN
    localparam logic LRCLK_RST = 1'b1;
`else
    localparam logic LRCLK_RST = 1'b0;
`endif

    logic [DW-1:0]      div_cnt_q, div_cnt_d;
    logic               bclk_q, bclk_d;
    logic [5:0]         bit_cnt_q, bit_cnt_d;
    logic               lrclk_q, lrclk_d;
    logic               sdata_q, sdata_d;
    logic [31:0]        held_q, held_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   level_q, level_d;
    logic               ovf_q, ovf_d;
    logic               und_q, und_d;
    logic [31:0]        mem_q [DEPTH];

    logic        div_wrap, shift_tick, frame_tick;
    logic        fifo_empty, fifo_full, pop, push;
    logic [15:0] slot_word;
    logic [4:0]  slot_pos;
    logic [4:0]  bit_idx;
    logic        next_bit;

    always_comb begin
        div_wrap   = (div_cnt_q == DW'(BCLK_DIV - 1));
        shift_tick = div_wrap & bclk_q;
        frame_tick = shift_tick & (bit_cnt_q == 6'd63);
        fifo_empty = (level_q == '0);
        fifo_full  = (level_q == (FIFO_AW + 1)'(DEPTH));
        // A frame-start pop frees a slot for a push landing on the same clock.
        pop        = frame_tick & ~fifo_empty;
        push       = sample_valid & (~fifo_full | pop);

        div_cnt_d  = div_wrap ? '0 : div_cnt_q + DW'(1);
        bclk_d     = div_wrap ? ~bclk_q : bclk_q;
        bit_cnt_d  = shift_tick ? bit_cnt_q + 6'd1 : bit_cnt_q;
        held_d     = pop ? mem_q[rd_ptr_q] : held_q;
        rd_ptr_d   = rd_ptr_q + FIFO_AW'(pop);
        wr_ptr_d   = wr_ptr_q + FIFO_AW'(push);
        level_d    = level_q + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
        ovf_d      = (ovf_q & ~clr_flags) | (sample_valid & ~push);
        und_d      = (und_q & ~clr_flags) | (frame_tick & fifo_empty);

        slot_word  = bit_cnt_d[5] ? held_d[15:0] : held_d[31:16];
        slot_pos   = bit_cnt_d[4:0];
`ifdef AUDIO_I2S_LJ_EN
        bit_idx    = 5'd15 - slot_pos;
        next_bit   = ~slot_pos[4] & slot_word[bit_idx[3:0]];
        lrclk_d    = shift_tick ? ~bit_cnt_d[5] : lrclk_q;
`else
        bit_idx    = 5'd16 - slot_pos;
        next_bit   = (slot_pos >= 5'd1) && (slot_pos <= 5'd16) && slot_word[bit_idx[3:0]];
        lrclk_d    = shift_tick ? bit_cnt_d[5] : lrclk_q;
`endif
        sdata_d    = shift_tick ? next_bit : sdata_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
            bit_cnt_q <= '0;
            lrclk_q   <= LRCLK_RST;
            sdata_q   <= 1'b0;
            held_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
            und_q     <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
            bit_cnt_q <= bit_cnt_d;
            lrclk_q   <= lrclk_d;
            sdata_q   <= sdata_d;
            held_q    <= held_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
            und_q     <= und_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {sample_l, sample_r};
        end
    end

    assign fifo_level = level_q;
    assign overflow   = ovf_q;
    assign underrun   = und_q;
    assign i2s_bclk   = bclk_q;
    assign i2s_lrclk  = lrclk_q;
    assign i2s_sdata  = sdata_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed + randomized bench for audio_i2s_tx; expected outputs come from a frame-timing model.
module tb_audio_i2s_tx;

    localparam int unsigned DIV   = 4;
    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned FRAME = 128 * DIV;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] sample_l = '0;
    logic [15:0] sample_r = '0;
    logic        sample_valid = 1'b0;
    logic        clr_flags = 1'b0;
    logic [AW:0] fifo_level;
    logic        overflow, underrun, i2s_bclk, i2s_lrclk, i2s_sdata;

    audio_i2s_tx #(.BCLK_DIV(DIV), .FIFO_AW(AW)) dut (
        .clk(clk), .reset_n(reset_n), .sample_l(sample_l), .sample_r(sample_r),
        .sample_valid(sample_valid), .clr_flags(clr_flags), .fifo_level(fifo_level),
        .overflow(overflow), .underrun(underrun), .i2s_bclk(i2s_bclk),
        .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int unsigned k = 0;
    logic [31:0] q [$];
    logic [31:0] held = '0;
    logic        m_ovf = 1'b0;
    logic        m_und = 1'b0;
`ifdef AUDIO_I2S_LJ_EN
    localparam logic LJ = 1'b1;
`else
    localparam logic LJ = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at k=%0d", tag, obs, exp, k);
        end
    endtask

    // Bit position within the frame after k posedges since reset release.
    function automatic int unsigned frame_bit();
        return (k / (2 * DIV)) % 64;
    endfunction

    function automatic logic exp_sdata();
        int unsigned n = frame_bit();
        int unsigned s = n % 32;
        logic [15:0] word = (n < 32) ? held[31:16] : held[15:0];
        if (LJ) return (s <= 15) ? word[15 - s] : 1'b0;
        return (s >= 1 && s <= 16) ? word[16 - s] : 1'b0;
    endfunction

    task automatic check_all();
        logic lr = (frame_bit() >= 32);
        check("bclk", 32'(i2s_bclk), 32'((k / DIV) % 2));
        check("lrclk", 32'(i2s_lrclk), 32'(LJ ? ~lr : lr));
        check("sdata", 32'(i2s_sdata), 32'(exp_sdata()));
        check("level", 32'(fifo_level), 32'(q.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underrun", 32'(underrun), 32'(m_und));
    endtask

    task automatic step(input logic v, input logic [15:0] l, input logic [15:0] r, input logic c);
        logic ovf_set = 1'b0;
        logic und_set = 1'b0;
        sample_valid = v; sample_l = l; sample_r = r; clr_flags = c;
        @(posedge clk);
        k++;
        if (k % (2 * DIV) == 0 && (k / (2 * DIV)) % 64 == 0) begin
            if (q.size() > 0) held = q.pop_front();
            else und_set = 1'b1;
        end
        if (v) begin
            if (q.size() < DEPTH) q.push_back({l, r});
            else ovf_set = 1'b1;
        end
        m_ovf = (m_ovf & ~c) | ovf_set;
        m_und = (m_und & ~c) | und_set;
        #1;
        check_all();
        sample_valid = 1'b0; clr_flags = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0);
    endtask

    task automatic idle_until(input int unsigned pos);
        while ((k % FRAME) != pos) step(1'b0, '0, '0, 1'b0);
    endtask

    task automatic push_rand();
        step(1'b1, 16'($urandom), 16'($urandom), 1'b0);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        #1;
        check("rst_bclk", 32'(i2s_bclk), 32'd0);
        check("rst_lrclk", 32'(i2s_lrclk), 32'(LJ));
        check("rst_sdata", 32'(i2s_sdata), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        q.delete(); held = '0; m_ovf = 1'b0; m_und = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        k = 0;
    endtask

    initial begin
        #1;
        apply_reset();

        // Idle after reset: clocks run, zeros shifted, underrun at first wrap.
        idle(FRAME + 40);

        // Boundary-valued pair, then repeated on the next empty frame.
        step(1'b0, '0, '0, 1'b1);
        idle_until(100);
        step(1'b1, 16'h8001, 16'h7FFE, 1'b0);
        idle(2 * FRAME);

        // Six back-to-back pushes: four kept, two dropped with overflow.
        idle_until(10);
        for (int unsigned i = 0; i < 6; i++) push_rand();
        idle(5 * FRAME);

        // Single pair repeated over empty frames; clear coincident with underrun.
        idle_until(10);
        step(1'b1, 16'h1234, 16'h5678, 1'b1);
        idle(FRAME);
        idle_until(300);
        step(1'b0, '0, '0, 1'b1);
        idle_until(FRAME - 1);
        step(1'b0, '0, '0, 1'b1);
        idle(FRAME + 20);

        // Full FIFO with a push landing on the frame-start pop.
        idle_until(100);
        for (int unsigned i = 0; i < DEPTH; i++) push_rand();
        step(1'b0, '0, '0, 1'b1);
        idle_until(FRAME - 1);
        push_rand();
        idle(5 * FRAME);

        // Random traffic with occasional flag clears.
        for (int unsigned i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) push_rand();
            else step(1'b0, '0, '0, ($urandom_range(0, 199) == 0));
        end

        // Reset in the middle of the right slot, then restart.
        while (frame_bit() != 40) push_rand();
        apply_reset();
        idle(FRAME + 10);
        step(1'b1, 16'h8001, 16'h7FFE, 1'b0);
        idle(2 * FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
